// File: rtl/omem_potential_store_if.sv
// omem_potential_store_if: packet-in / packet-out handshake bundle for the output memory
interface omem_potential_store_if;
    logic [32:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] out_data;
    logic        out_valid;
    logic        out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/omem_potential_store.sv
// omem_potential_store: per-PE residual potential store with spike events and timestep broadcast
module omem_potential_store #(
    parameter int NUM_PE        = 7,
    parameter int SLOTS_PER_PE  = 63,
    parameter int POT_W         = 13,
    parameter int OMEM_ID       = 12,
    parameter int SPE_ADDR_BASE = 0,
    parameter int NUM_TIMESTEPS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    omem_potential_store_if.slave bus,
    output logic                  spike_valid,
    output logic [2:0]            spike_pe,
    output logic [5:0]            spike_idx,
    output logic                  spike_bit,
    output logic [1:0]            spike_ts,
    output logic [1:0]            ts,
    output logic                  done,
    output logic                  err
);
    localparam int TOT = NUM_PE * SLOTS_PER_PE;
    localparam int AW  = $clog2(TOT);
    localparam int CW  = $clog2(TOT + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RESP  = 2'd1;
    localparam logic [1:0] BCAST = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [POT_W-1:0] pot [TOT];
    logic [1:0]  state_q, state_d;
    logic [5:0]  ptr_q [NUM_PE];
    logic [5:0]  ptr_d [NUM_PE];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  ts_q, ts_d;
    logic        err_q, err_d;
    logic        rdy_q;
    logic        ov_q, ov_d;
    logic [32:0] od_q, od_d;
    logic [2:0]  bidx_q, bidx_d;
    logic        sv_q, sv_d;
    logic [2:0]  spe_q, spe_d;
    logic [5:0]  sidx_q, sidx_d;
    logic        sbit_q, sbit_d;
    logic [1:0]  sts_q, sts_d;
    logic [3:0]  addr;
    logic [2:0]  pe, pe_s;
    logic        rd, bad, acc, last, we;
    logic [5:0]  cur;
    logic [AW-1:0] widx;
    logic        unused_bits;

    function automatic logic [32:0] bpkt(input logic [2:0] i);
        return {4'(SPE_ADDR_BASE) + {1'b0, i}, 4'd15, 25'd0};
    endfunction

    assign addr        = bus.in_data[32:29];
    assign pe          = bus.in_data[28:26];
    assign rd          = bus.in_data[25];
    assign unused_bits = ^bus.in_data[24:14];
    assign bad         = addr != 4'(OMEM_ID) || 32'(pe) >= NUM_PE;
    assign pe_s        = bad ? 3'd0 : pe;
    assign cur         = ptr_q[pe_s];
    assign widx        = AW'(pe_s) * AW'(SLOTS_PER_PE) + AW'(cur);
    assign acc         = bus.in_valid && rdy_q;
    assign last        = cnt_q == CW'(TOT - 1);

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign spike_valid   = sv_q;
    assign spike_pe      = spe_q;
    assign spike_idx     = sidx_q;
    assign spike_bit     = sbit_q;
    assign spike_ts      = sts_q;
    assign ts            = ts_q;
    assign done          = state_q == DONE;
    assign err           = err_q;

    // Decode accepted packets, sequence responses/broadcasts and track timestep progress
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        err_d   = err_q;
        ov_d    = ov_q;
        od_d    = od_q;
        bidx_d  = bidx_q;
        sv_d    = 1'b0;
        spe_d   = spe_q;
        sidx_d  = sidx_q;
        sbit_d  = sbit_q;
        sts_d   = sts_q;
        we      = 1'b0;
        if (state_q == IDLE && acc) begin
            if (bad) begin
                err_d = 1'b1;
            end else if (rd) begin
                od_d    = {4'(SPE_ADDR_BASE) + {1'b0, pe_s}, 4'd2,
                           25'(ts_q == 2'd1 ? {POT_W{1'b0}} : pot[widx])};
                ov_d    = 1'b1;
                state_d = RESP;
            end else begin
                we            = 1'b1;
                sv_d          = 1'b1;
                spe_d         = pe_s;
                sidx_d        = cur;
                sbit_d        = bus.in_data[0];
                sts_d         = ts_q;
                ptr_d[pe_s]   = cur == 6'(SLOTS_PER_PE - 1) ? 6'd0 : cur + 6'd1;
                cnt_d         = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    if (ts_q == 2'(NUM_TIMESTEPS)) begin
                        state_d = DONE;
                    end else if (ts_q == 2'd1) begin
                        ts_d    = 2'd2;
                        state_d = BCAST;
                        bidx_d  = 3'd0;
                        ov_d    = 1'b1;
                        od_d    = bpkt(3'd0);
                    end else begin
                        ts_d = ts_q + 2'd1;
                    end
                end
            end
        end else if (state_q == RESP && bus.out_ready) begin
            ov_d    = 1'b0;
            state_d = IDLE;
        end else if (state_q == BCAST && bus.out_ready) begin
            if (bidx_q == 3'(NUM_PE - 1)) begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end else begin
                bidx_d = bidx_q + 3'd1;
                od_d   = bpkt(bidx_q + 3'd1);
            end
        end
    end

    // Control and status registers; in_ready follows the next state so it is 0 during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_PE; i++) ptr_q[i] <= '0;
            cnt_q   <= '0;
            ts_q    <= 2'd1;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            bidx_q  <= '0;
            sv_q    <= 1'b0;
            spe_q   <= '0;
            sidx_q  <= '0;
            sbit_q  <= 1'b0;
            sts_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            err_q   <= err_d;
            rdy_q   <= state_d == IDLE;
            ov_q    <= ov_d;
            od_q    <= od_d;
            bidx_q  <= bidx_d;
            sv_q    <= sv_d;
            spe_q   <= spe_d;
            sidx_q  <= sidx_d;
            sbit_q  <= sbit_d;
            sts_q   <= sts_d;
        end
    end

    // Potential array holds residuals across timesteps and is deliberately not reset
    always_ff @(posedge clk) begin
        if (we) pot[widx] <= bus.in_data[POT_W:1];
    end
endmodule
